// File: rtl/ahb_sram_arbiter.sv
// Two-master round-robin AHB arbiter feeding one SRAM controller slave port.
// Optional macro ARB_TIMEOUT_EN adds a hold counter that forces a hand-over after HOLD_LIMIT cycles.
module ahb_sram_arbiter #(
   parameter int ADDR_WIDTH     = 32,
   parameter int DATA_WIDTH     = 32,
   parameter bit DEFAULT_MASTER = 1'b0,
   parameter int HOLD_LIMIT     = 16
) (
   input  logic                  hclk,
   input  logic                  hreset,
   input  logic                  m0_hbusreq,
   input  logic                  m1_hbusreq,
   input  logic [ADDR_WIDTH-1:0] m0_haddr,
   input  logic [ADDR_WIDTH-1:0] m1_haddr,
   input  logic [1:0]            m0_htrans,
   input  logic [1:0]            m1_htrans,
   input  logic                  m0_hwrite,
   input  logic                  m1_hwrite,
   input  logic [2:0]            m0_hsize,
   input  logic [2:0]            m1_hsize,
   input  logic [2:0]            m0_hburst,
   input  logic [2:0]            m1_hburst,
   input  logic [DATA_WIDTH-1:0] m0_hwdata,
   input  logic [DATA_WIDTH-1:0] m1_hwdata,
   input  logic                  hready,
   output logic                  hgrant_m0,
   output logic                  hgrant_m1,
   output logic                  hmaster,
   output logic [ADDR_WIDTH-1:0] haddr,
   output logic [1:0]            htrans,
   output logic                  hwrite,
   output logic [2:0]            hsize,
   output logic [2:0]            hburst,
   output logic [DATA_WIDTH-1:0] hwdata
);

   typedef enum logic [1:0] {
      HT_IDLE   = 2'd0,
      HT_BUSY   = 2'd1,
      HT_NONSEQ = 2'd2,
      HT_SEQ    = 2'd3
   } htrans_e;

   logic       grant_q, grant_d;
   logic       hmaster_q;
   logic       hmaster_dp_q;
   logic [3:0] bcnt_q, bcnt_d;
   logic       last_winner_q, last_winner_d;
   logic       parked_q, parked_d;
   logic       arb_ok;
   logic       timeout;

   // Beats remaining after the first one of a fixed-length burst.
   function automatic logic [3:0] burst_beats_left(input logic [2:0] burst);
      case (burst)
         3'b010, 3'b011: burst_beats_left = 4'd3;
         3'b100, 3'b101: burst_beats_left = 4'd7;
         3'b110, 3'b111: burst_beats_left = 4'd15;
         default:        burst_beats_left = 4'd0;
      endcase
   endfunction

   assign hgrant_m0 = ~grant_q;
   assign hgrant_m1 = grant_q;
   assign hmaster   = hmaster_q;

   assign haddr  = hmaster_q ? m1_haddr  : m0_haddr;
   assign htrans = hmaster_q ? m1_htrans : m0_htrans;
   assign hwrite = hmaster_q ? m1_hwrite : m0_hwrite;
   assign hsize  = hmaster_q ? m1_hsize  : m0_hsize;
   assign hburst = hmaster_q ? m1_hburst : m0_hburst;
   assign hwdata = hmaster_dp_q ? m1_hwdata : m0_hwdata;

   always_comb begin
      // NOTE: every always_comb output gets a default first, so no path can infer a latch.
      bcnt_d = bcnt_q;
      if (hready) begin
         if (htrans == HT_NONSEQ) begin
            bcnt_d = burst_beats_left(hburst);
         end else if (htrans == HT_SEQ && bcnt_q != 4'd0) begin
            bcnt_d = bcnt_q - 4'd1;
         end
      end
   end

   assign arb_ok = hready && (bcnt_d <= 4'd1);

   always_comb begin
      grant_d  = grant_q;
      parked_d = parked_q;
      if (arb_ok) begin
         unique case ({m1_hbusreq, m0_hbusreq})
            2'b00: begin
               grant_d  = DEFAULT_MASTER;
               parked_d = 1'b1;
            end
            2'b01: begin
               grant_d  = 1'b0;
               parked_d = 1'b0;
            end
            2'b10: begin
               grant_d  = 1'b1;
               parked_d = 1'b0;
            end
            default: begin
               parked_d = 1'b0;
               // A parked grant or the final beat of a fixed burst hands over round-robin.
               if (bcnt_d != 4'd0 || parked_q || timeout) begin
                  grant_d = ~last_winner_q;
               end
            end
         endcase
      end
      last_winner_d = (grant_d != grant_q) ? grant_d : last_winner_q;
   end

   always_ff @(posedge hclk) begin
      // NOTE: non-blocking assignments so every flop samples pre-edge values regardless of order.
      if (hreset) begin
         grant_q       <= DEFAULT_MASTER;
         hmaster_q     <= DEFAULT_MASTER;
         hmaster_dp_q  <= DEFAULT_MASTER;
         bcnt_q        <= 4'd0;
         last_winner_q <= DEFAULT_MASTER;
         parked_q      <= 1'b1;
      end else if (hready) begin
         grant_q       <= grant_d;
         hmaster_q     <= grant_q;
         hmaster_dp_q  <= hmaster_q;
         bcnt_q        <= bcnt_d;
         last_winner_q <= last_winner_d;
         parked_q      <= parked_d;
      end
   end

`ifdef ARB_TIMEOUT_EN
   localparam int HOLD_W = $clog2(HOLD_LIMIT + 1);

   logic [HOLD_W-1:0] hold_cnt_q, hold_cnt_d;

   always_comb begin
      hold_cnt_d = hold_cnt_q;
      if (grant_d != grant_q) begin
         hold_cnt_d = '0;
      end else if (hready && bcnt_d == 4'd0 && hold_cnt_q != HOLD_W'(HOLD_LIMIT)) begin
         hold_cnt_d = hold_cnt_q + HOLD_W'(1);
      end
   end

   assign timeout = (hold_cnt_q == HOLD_W'(HOLD_LIMIT));

   always_ff @(posedge hclk) begin
      if (hreset) begin
         hold_cnt_q <= '0;
      end else begin
         hold_cnt_q <= hold_cnt_d;
      end
   end
`else
   // Without the hold counter the owner of undefined-length transfers is never pre-empted.
   assign timeout = (HOLD_LIMIT < 0);
`endif

endmodule

// File: tb/tb_ahb_sram_arbiter.sv
// Scoreboard bench for ahb_sram_arbiter: stimulus pushes hand-derived grant/owner
// expectations, a negedge monitor pops and compares them against the muxed bus.
module tb_ahb_sram_arbiter;

   localparam logic [1:0] ID = 2'd0;
   localparam logic [1:0] NS = 2'd2;
   localparam logic [1:0] SQ = 2'd3;
   localparam logic [2:0] SINGLE = 3'b000;
   localparam logic [2:0] INCR   = 3'b001;
   localparam logic [2:0] INCR4  = 3'b011;
   localparam logic [2:0] INCR8  = 3'b101;

   logic        hclk = 1'b0;
   logic        hreset = 1'b1;
   logic        m0_hbusreq = 1'b0, m1_hbusreq = 1'b0;
   logic [31:0] m0_haddr = '0, m1_haddr = '0;
   logic [1:0]  m0_htrans = ID, m1_htrans = ID;
   logic        m0_hwrite = 1'b1, m1_hwrite = 1'b0;
   logic [2:0]  m0_hsize = 3'd2, m1_hsize = 3'd1;
   logic [2:0]  m0_hburst = SINGLE, m1_hburst = SINGLE;
   logic [31:0] m0_hwdata = 32'hA0A0_0000, m1_hwdata = 32'hB1B1_1111;
   logic        hready = 1'b1;
   logic        hgrant_m0, hgrant_m1, hmaster, hwrite;
   logic [31:0] haddr, hwdata;
   logic [1:0]  htrans;
   logic [2:0]  hsize, hburst;

   ahb_sram_arbiter #(
      .ADDR_WIDTH(32), .DATA_WIDTH(32), .DEFAULT_MASTER(1'b0), .HOLD_LIMIT(4)
   ) dut (
      .hclk(hclk), .hreset(hreset),
      .m0_hbusreq(m0_hbusreq), .m1_hbusreq(m1_hbusreq),
      .m0_haddr(m0_haddr), .m1_haddr(m1_haddr),
      .m0_htrans(m0_htrans), .m1_htrans(m1_htrans),
      .m0_hwrite(m0_hwrite), .m1_hwrite(m1_hwrite),
      .m0_hsize(m0_hsize), .m1_hsize(m1_hsize),
      .m0_hburst(m0_hburst), .m1_hburst(m1_hburst),
      .m0_hwdata(m0_hwdata), .m1_hwdata(m1_hwdata),
      .hready(hready),
      .hgrant_m0(hgrant_m0), .hgrant_m1(hgrant_m1), .hmaster(hmaster),
      .haddr(haddr), .htrans(htrans), .hwrite(hwrite), .hsize(hsize), .hburst(hburst),
      .hwdata(hwdata)
   );

   always #5 hclk = ~hclk;

   typedef struct {
      string       name;
      logic [1:0]  gnt;
      logic        hm;
      logic [31:0] addr;
      logic [1:0]  trans;
      logic [6:0]  ctrl;
      logic [31:0] wdata;
   } exp_t;

   exp_t sb[$];
   int   n_checks = 0;
   int   n_errors = 0;
   bit   moved = 1'b0;

   task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
      n_checks++;
      if (act !== exp) begin
         n_errors++;
         $display("FAIL %s: got %h expected %h", name, act, exp);
      end
   endtask

   task automatic m0(input logic [1:0] t, input logic [2:0] b, input logic [31:0] a);
      m0_htrans = t; m0_hburst = b; m0_haddr = a;
   endtask

   task automatic m1(input logic [1:0] t, input logic [2:0] b, input logic [31:0] a);
      m1_htrans = t; m1_hburst = b; m1_haddr = a;
   endtask

   // Drive one cycle; eg/ehm/ehmd are the hand-derived grant, address owner and data owner
   // expected in this cycle (i.e. after the previous edge).
   task automatic cyc(input string name, input bit r0, input bit r1, input bit rdy,
                      input bit eg, input bit ehm, input bit ehmd);
      exp_t e;
      m0_hbusreq = r0; m1_hbusreq = r1; hready = rdy;
      e.name  = name;
      e.gnt   = eg ? 2'b10 : 2'b01;
      e.hm    = ehm;
      e.addr  = ehm ? m1_haddr : m0_haddr;
      e.trans = ehm ? m1_htrans : m0_htrans;
      e.ctrl  = ehm ? {m1_hwrite, m1_hsize, m1_hburst} : {m0_hwrite, m0_hsize, m0_hburst};
      e.wdata = ehmd ? m1_hwdata : m0_hwdata;
      sb.push_back(e);
      @(posedge hclk);
      #1;
   endtask

   always @(negedge hclk) begin
      if (sb.size() > 0) begin
         exp_t e;
         e = sb.pop_front();
         check({e.name, ".gnt"},   32'({hgrant_m1, hgrant_m0}), 32'(e.gnt));
         check({e.name, ".hmstr"}, 32'(hmaster), 32'(e.hm));
         check({e.name, ".haddr"}, haddr, e.addr);
         check({e.name, ".ctrl"},  32'({htrans, hwrite, hsize, hburst}), 32'({e.trans, e.ctrl}));
         check({e.name, ".hwdata"}, hwdata, e.wdata);
      end
   end

   initial begin
      #200000;
      $display("FAIL watchdog: simulation time limit reached");
      $fatal(1, "watchdog");
   end

   initial begin
      m1(ID, SINGLE, 32'h10);
      repeat (2) @(posedge hclk);
      #1;
      hreset = 1'b0;

      // Reset state, then m1 alone takes the bus
      cyc("reset",       0, 1, 1, 0, 0, 0);
      cyc("m1_grant",    0, 1, 1, 1, 0, 0);
      m1(NS, SINGLE, 32'h10);
      cyc("m1_addr",     0, 1, 1, 1, 1, 0);
      m1(ID, SINGLE, 32'h10);
      cyc("m1_data",     0, 0, 1, 1, 1, 1);
      cyc("park",        0, 0, 1, 0, 1, 1);
      cyc("park_hm",     0, 0, 1, 0, 0, 1);

      // m0 INCR4 locked, m1 requests mid-burst
      m0(NS, INCR4, 32'h100);
      cyc("incr4_b0",    1, 0, 1, 0, 0, 0);
      m0(SQ, INCR4, 32'h104);
      cyc("incr4_b1",    1, 1, 1, 0, 0, 0);
      m0(SQ, INCR4, 32'h108);
      cyc("incr4_b2",    1, 1, 1, 0, 0, 0);
      m0(SQ, INCR4, 32'h10C);
      cyc("incr4_b3",    0, 1, 1, 1, 0, 0);
      m0(ID, INCR4, 32'h10C);
      m1(NS, SINGLE, 32'h200);
      cyc("m1_after",    0, 1, 1, 1, 1, 0);
      m1(ID, SINGLE, 32'h200);
      cyc("m1_done",     0, 0, 1, 1, 1, 1);
      cyc("park2",       0, 0, 1, 0, 1, 1);
      cyc("park2_hm",    0, 0, 1, 0, 0, 1);

      // Both request from idle, then alternate SINGLE transfers
      cyc("both_idle",   1, 1, 1, 0, 0, 0);
      cyc("alt_m1_gnt",  1, 1, 1, 1, 0, 0);
      m1(NS, SINGLE, 32'h300);
      cyc("alt_m1_xfer", 1, 0, 1, 1, 1, 0);
      m1(ID, SINGLE, 32'h300);
      cyc("alt_m0_gnt",  1, 1, 1, 0, 1, 1);
      m0(NS, SINGLE, 32'h400);
      cyc("alt_m0_xfer", 0, 1, 1, 0, 0, 1);
      m0(ID, SINGLE, 32'h400);
      cyc("alt_m1_gnt2", 1, 1, 1, 1, 0, 0);
      m1(NS, SINGLE, 32'h304);
      cyc("alt_m1_xfr2", 1, 0, 1, 1, 1, 0);
      m1(ID, SINGLE, 32'h304);
      cyc("alt_m0_gnt2", 0, 0, 1, 0, 1, 1);
      cyc("alt_end",     0, 0, 1, 0, 0, 1);

      // INCR8 with a three-cycle hready stall
      m0(NS, INCR8, 32'h500);
      cyc("incr8_b0",    1, 0, 1, 0, 0, 0);
      m0(SQ, INCR8, 32'h504);
      cyc("incr8_b1",    1, 1, 1, 0, 0, 0);
      m0(SQ, INCR8, 32'h508);
      for (int i = 0; i < 3; i++) cyc("stall", 1, 1, 0, 0, 0, 0);
      for (int i = 0; i < 5; i++) begin
         m0(SQ, INCR8, 32'h508 + 32'(4 * i));
         cyc("incr8_mid", 1, 1, 1, 0, 0, 0);
      end
      m0(SQ, INCR8, 32'h51C);
      cyc("incr8_b7",    0, 1, 1, 1, 0, 0);
      m0(ID, INCR8, 32'h51C);
      m1(ID, SINGLE, 32'h0);
      cyc("incr8_end",   0, 0, 1, 1, 1, 0);
      cyc("incr8_park",  0, 0, 1, 0, 1, 1);
      cyc("incr8_park2", 0, 0, 1, 0, 0, 1);

      // Reset in the middle of an m1 burst
      cyc("rst_pre",     0, 1, 1, 0, 0, 0);
      cyc("rst_pre_gnt", 0, 1, 1, 1, 0, 0);
      m1(NS, INCR4, 32'h700);
      cyc("rst_b0",      0, 1, 1, 1, 1, 0);
      m1(SQ, INCR4, 32'h704);
      hreset = 1'b1;
      cyc("rst_mid",     0, 1, 1, 1, 1, 1);
      hreset = 1'b0;
      m1(ID, INCR4, 32'h704);
      cyc("rst_after",   0, 1, 1, 0, 0, 0);
      cyc("rst_regrant", 0, 0, 1, 1, 0, 0);
      cyc("rst_park",    0, 0, 1, 0, 1, 0);
      cyc("rst_park2",   0, 0, 1, 0, 0, 1);

      // m0 undefined-length INCR with hbusreq held while m1 also requests
      m0(NS, INCR, 32'h600);
      cyc("incr_hold0",  1, 0, 1, 0, 0, 0);
`ifdef ARB_TIMEOUT_EN
      for (int i = 0; i < 20 && !moved; i++) begin
         m0(SQ, INCR, 32'h604 + 32'(4 * i));
         m0_hbusreq = 1'b1; m1_hbusreq = 1'b1; hready = 1'b1;
         @(posedge hclk);
         #1;
         if (hgrant_m1) moved = 1'b1;
      end
      check("timeout_switch", 32'(moved), 32'd1);
      m0(ID, INCR, 32'h0);
      m0_hbusreq = 1'b0; m1_hbusreq = 1'b0;
      repeat (4) @(posedge hclk);
      #1;
`else
      for (int i = 0; i < 10; i++) begin
         m0(SQ, INCR, 32'h604 + 32'(4 * i));
         cyc("incr_hold", 1, 1, 1, 0, 0, 0);
      end
      m0(ID, INCR, 32'h628);
      cyc("incr_drop",   0, 0, 1, 0, 0, 0);
      cyc("idle_end",    0, 0, 1, 0, 0, 0);
`endif

      for (int i = 0; i < 10 && sb.size() > 0; i++) @(negedge hclk);
      check("sb_drain", 32'(sb.size()), 32'd0);
      $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
      $finish;
   end

endmodule
